word_serializer: RTL and testbench

WORD_SERIALIZER -- requirements
Module: word_serializer

---
 rtl/word_serializer.sv | 114 +++++++++++
 tb/tb_word_serializer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/word_serializer.sv
// LSB-first word serializer with start/stop framing and a bit-rate clock enable.
// Define WORD_SERIALIZER_PARITY_EN to insert an even-parity bit before the stop bit.
module word_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             enable_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic             serial_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH);

  // state    | meaning
  // S_IDLE   | line high, waiting for a word
  // S_START  | start bit (0) on the line
  // S_DATA   | data bits, LSB first
  // S_PARITY | even-parity bit (parity build only)
  // S_STOP   | stop bit (1), done_o pulses
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
`ifdef WORD_SERIALIZER_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]       r_state;
  logic [WIDTH-1:0] r_shift;
  logic [CW-1:0]    r_cnt;
  logic             r_serial;
  logic             r_busy;
`ifdef WORD_SERIALIZER_PARITY_EN
  logic             r_parity;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state  <= S_IDLE;
      r_shift  <= '0;
      r_cnt    <= '0;
      r_serial <= 1'b1;
      r_busy   <= 1'b0;
`ifdef WORD_SERIALIZER_PARITY_EN
      r_parity <= 1'b0;
`endif
    end else if (enable_i) begin
      case (r_state)
        S_IDLE: begin
          if (valid_i) begin
            r_shift  <= data_i;
            r_cnt    <= '0;
            r_state  <= S_START;
            r_serial <= 1'b0;
            r_busy   <= 1'b1;
`ifdef WORD_SERIALIZER_PARITY_EN
            r_parity <= ^data_i;
`endif
          end
        end
        S_START: begin
          r_serial <= r_shift[0];
          r_shift  <= r_shift >> 1;
          r_cnt    <= CW'(1);
          r_state  <= S_DATA;
        end
        S_DATA: begin
          // r_cnt counts bits already placed on the line, so it tops out at WIDTH
          if (r_cnt == LAST_BIT) begin
`ifdef WORD_SERIALIZER_PARITY_EN
            r_serial <= r_parity;
            r_state  <= S_PARITY;
`else
            r_serial <= 1'b1;
            r_state  <= S_STOP;
`endif
          end else begin
            r_serial <= r_shift[0];
            r_shift  <= r_shift >> 1;
            r_cnt    <= r_cnt + CW'(1);
          end
        end
`ifdef WORD_SERIALIZER_PARITY_EN
        S_PARITY: begin
          r_serial <= 1'b1;
          r_state  <= S_STOP;
        end
`endif
        S_STOP: begin
          r_serial <= 1'b1;
          r_busy   <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: begin
          r_serial <= 1'b1;
          r_busy   <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

  assign ready_o  = (r_state == S_IDLE) && rst_i;
  assign serial_o = r_serial;
  assign busy_o   = r_busy;
  assign done_o   = (r_state == S_STOP) && enable_i && rst_i;

endmodule

// File: tb/tb_word_serializer.sv
// Scoreboard bench for word_serializer: stimulus pushes expected frames, a negedge
// monitor rebuilds frames from serial_o and compares. Honours WORD_SERIALIZER_PARITY_EN.
module tb_word_serializer;
  localparam int WIDTH = 8;
`ifdef WORD_SERIALIZER_PARITY_EN
  localparam int FLEN = WIDTH + 3;
`else
  localparam int FLEN = WIDTH + 2;
`endif

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b0;
  logic             enable_i = 1'b0;
  logic [WIDTH-1:0] data_i = '0;
  logic             valid_i = 1'b0;
  logic             ready_o, serial_o, busy_o, done_o;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  logic [15:0] exp_bits[$];
  int          exp_len[$];

  word_serializer #(.WIDTH(WIDTH)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i), .data_i(data_i),
    .valid_i(valid_i), .ready_o(ready_o), .serial_o(serial_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [15:0] frame_of(input logic [WIDTH-1:0] d);
    logic [15:0] f;
    f = '0;
    for (int i = 0; i < WIDTH; i++) f[1+i] = d[i];
`ifdef WORD_SERIALIZER_PARITY_EN
    f[WIDTH+1] = ^d;
    f[WIDTH+2] = 1'b1;
`else
    f[WIDTH+1] = 1'b1;
`endif
    return f;
  endfunction

  task automatic push(input logic [15:0] bits);
    exp_bits.push_back(bits);
    exp_len.push_back(FLEN);
  endtask

  task automatic wait_ready();
    int k;
    k = 0;
    while (!ready_o && k < 100) begin tick(); k++; end
    check("ready_timeout", {31'd0, ready_o}, 32'd1);
  endtask

  task automatic send(input logic [WIDTH-1:0] d, input logic [15:0] bits);
    wait_ready();
    data_i = d; valid_i = 1'b1; enable_i = 1'b1;
    tick();
    valid_i = 1'b0; data_i = ~d;
    push(bits);
  endtask

  // Monitor: one bit per enabled busy cycle; a frame closes on done_o.
  logic [15:0] cur;
  int          ncur = 0;
  always @(negedge clk_i) begin
    if (mon_en) begin
      check("done_gating", {31'd0, done_o && (!enable_i || !busy_o)}, 32'd0);
      if (!busy_o) begin
        ncur = 0;
        cur  = '0;
        check("idle_line", {31'd0, serial_o}, 32'd1);
      end else if (enable_i) begin
        if (ncur < 16) cur[ncur] = serial_o;
        ncur++;
        if (done_o) begin
          if (exp_bits.size() == 0) begin
            check("unexpected_frame", 32'd1, 32'd0);
          end else begin
            check("frame_len", ncur, exp_len.pop_front());
            check("frame_bits", {16'd0, cur}, {16'd0, exp_bits.pop_front()});
          end
          ncur = 0;
          cur  = '0;
        end
      end
    end
  end

  initial begin
    int t1, t2, k;
    // reset with enable low must still initialise everything
    rst_i = 1'b0; enable_i = 1'b0;
    tick(); tick();
    check("rst_serial", {31'd0, serial_o}, 32'd1);
    check("rst_busy",   {31'd0, busy_o},   32'd0);
    check("rst_done",   {31'd0, done_o},   32'd0);
    check("rst_ready",  {31'd0, ready_o},  32'd0);
    rst_i = 1'b1; enable_i = 1'b1;
    #1;
    check("ready_after_rst", {31'd0, ready_o}, 32'd1);
    mon_en = 1'b1;

`ifdef WORD_SERIALIZER_PARITY_EN
    send(8'hA5, 16'h054A);
    send(8'h07, 16'h060E);
`else
    send(8'hA5, 16'h034A);
    send(8'h07, 16'h020E);
`endif
    send(8'h00, frame_of(8'h00));
    send(8'hFF, frame_of(8'hFF));

    // enable toggling: each bit held two cycles
    wait_ready();
    data_i = 8'h3C; valid_i = 1'b1; enable_i = 1'b1;
    tick();
    valid_i = 1'b0; data_i = 8'h00;
    push(frame_of(8'h3C));
    for (int i = 0; i < 2 * FLEN + 2; i++) begin
      enable_i = (i % 2 == 1);
      tick();
    end
    enable_i = 1'b1;

    // valid held high across a busy frame
    wait_ready();
    data_i = 8'h11; valid_i = 1'b1;
    tick();
    t1 = cyc;
    push(frame_of(8'h11));
    check("ready_low_busy", {31'd0, ready_o}, 32'd0);
    data_i = 8'h22;
    k = 0;
    while (!ready_o && k < 100) begin tick(); k++; end
    tick();
    t2 = cyc;
    valid_i = 1'b0;
    push(frame_of(8'h22));
    check("b2b_period", t2 - t1, FLEN + 1);

    // mid-frame reset on the 4th data bit
    wait_ready();
    data_i = 8'hF0; valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("abort_bit3", {31'd0, serial_o}, 32'd0);
    rst_i = 1'b0;
    tick();
    check("abort_serial", {31'd0, serial_o}, 32'd1);
    check("abort_busy",   {31'd0, busy_o},   32'd0);
    check("abort_done",   {31'd0, done_o},   32'd0);
    rst_i = 1'b1;
    #1;
    check("abort_ready", {31'd0, ready_o}, 32'd1);
    send(8'hC3, frame_of(8'hC3));

    k = 0;
    while ((exp_bits.size() != 0 || busy_o) && k < 200) begin tick(); k++; end
    tick(); tick();
    check("queue_drained", exp_bits.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
